// File: rtl/any1_pkg.sv
// Shared constants and types for the instruction-line fetch path: bus cycle
// encodings, the fetch FSM state and the fetch-to-aligner output record.
package any1_pkg;

    localparam int BUS_BEAT_BITS = 128;
    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_EOB  = 3'b111;

    // Default geometry; the output record is sized from these.
    localparam int ILF_AWID  = 32;
    localparam int ILF_CSWID = 16;
    localparam int ILF_BEATS = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } ilf_state_t;

    // Field names follow the aligner input record; fault is extra.
    typedef struct packed {
        logic                                  v;
        logic [ILF_BEATS*BUS_BEAT_BITS-1:0]    ir;
        logic [ILF_AWID:0]                     ip;
        logic [ILF_CSWID-1:0]                  cs;
        logic [ILF_AWID:0]                     pip;
        logic                                  predict_taken;
        logic                                  fault;
    } sILineFetchOut;

endpackage

// File: rtl/any1_iline_buf.sv
// Line assembly buffer: BEATS slots of one bus beat each, written by index,
// cleared synchronously, presented as one flat vector (slot n at bits 128n+).
module any1_iline_buf
    import any1_pkg::*;
#(
    parameter int BEATS = ILF_BEATS,
    parameter int IW    = (BEATS > 1) ? $clog2(BEATS) : 1
)(
    input  logic                             rst,
    input  logic                             clk,
    input  logic                             clr,
    input  logic                             we,
    input  logic [IW-1:0]                    idx,
    input  logic [BUS_BEAT_BITS-1:0]         dat,
    output logic [BEATS*BUS_BEAT_BITS-1:0]   line
);

    logic [BUS_BEAT_BITS-1:0] slot_q [BEATS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BEATS; i++) slot_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < BEATS; i++) slot_q[i] <= '0;
        end else if (we && (int'(idx) < BEATS)) begin
            slot_q[idx] <= dat;
        end
    end

    for (genvar g = 0; g < BEATS; g++) begin : g_flat
        assign line[g*BUS_BEAT_BITS +: BUS_BEAT_BITS] = slot_q[g];
    end

endmodule

// File: rtl/any1_iline_fetch.sv
// Fetch-line producer: burst-reads the 64-byte line holding ip plus one overrun
// beat, then holds the assembled line with its request tags for the aligner.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high (req_i & req_rdy_o, out_v_o & out_rdy_i). Valid never depends on
// ready; once raised, out_v_o and the out_* payload stay stable until accepted.
module any1_iline_fetch
    import any1_pkg::*;
#(
    parameter int AWID  = ILF_AWID,
    parameter int CSWID = ILF_CSWID,
    parameter int BEATS = ILF_BEATS
)(
    input  logic                            rst_i,
    input  logic                            clk_i,
    input  logic                            flush_i,
    input  logic                            req_i,
    output logic                            req_rdy_o,
    input  logic [AWID:0]                   req_ip_i,
    input  logic [CSWID-1:0]                req_cs_i,
    input  logic [AWID:0]                   req_pip_i,
    input  logic                            req_pt_i,
    output logic                            cyc_o,
    output logic                            stb_o,
    output logic [2:0]                      cti_o,
    output logic [AWID-1:0]                 adr_o,
    input  logic                            ack_i,
    input  logic                            err_i,
    input  logic [BUS_BEAT_BITS-1:0]        dat_i,
    output logic                            out_v_o,
    input  logic                            out_rdy_i,
    output logic [BEATS*BUS_BEAT_BITS-1:0]  out_line_o,
    output logic [AWID:0]                   out_ip_o,
    output logic [CSWID-1:0]                out_cs_o,
    output logic [AWID:0]                   out_pip_o,
    output logic                            out_pt_o,
    output logic                            out_fault_o,
    output ilf_state_t                      state_o
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
    localparam logic [2:0] CTI_FIRST = (BEATS == 1) ? CTI_EOB : CTI_INCR;

    ilf_state_t        state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [AWID-1:0]   adr_q, adr_d;
    logic              cyc_q, cyc_d;
    logic [2:0]        cti_q, cti_d;
    logic              v_q, v_d;
    logic              fault_q, fault_d;
    logic [AWID:0]     ip_q, ip_d;
    logic [CSWID-1:0]  cs_q, cs_d;
    logic [AWID:0]     pip_q, pip_d;
    logic              pt_q, pt_d;

    logic              req_rdy;
    logic              buf_clr;
    logic              buf_we;
    logic [BEATS*BUS_BEAT_BITS-1:0] line;
    sILineFetchOut     ilf_out;

    any1_iline_buf #(.BEATS(BEATS), .IW(BW)) u_buf (
        .rst  (rst_i),
        .clk  (clk_i),
        .clr  (buf_clr),
        .we   (buf_we),
        .idx  (beat_q),
        .dat  (dat_i),
        .line (line)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
            adr_q   <= '0;
            cyc_q   <= 1'b0;
            cti_q   <= 3'b000;
            v_q     <= 1'b0;
            fault_q <= 1'b0;
            ip_q    <= '0;
            cs_q    <= '0;
            pip_q   <= '0;
            pt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            adr_q   <= adr_d;
            cyc_q   <= cyc_d;
            cti_q   <= cti_d;
            v_q     <= v_d;
            fault_q <= fault_d;
            ip_q    <= ip_d;
            cs_q    <= cs_d;
            pip_q   <= pip_d;
            pt_q    <= pt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        adr_d   = adr_q;
        cyc_d   = cyc_q;
        cti_d   = cti_q;
        v_d     = v_q;
        fault_d = fault_q;
        ip_d    = ip_q;
        cs_d    = cs_q;
        pip_d   = pip_q;
        pt_d    = pt_q;
        req_rdy = 1'b0;
        buf_clr = 1'b0;
        buf_we  = 1'b0;

        case (state_q)
            IDLE: begin
                req_rdy = 1'b1;
            end
            FILL: begin
                // err outranks a simultaneous ack: the beat is not stored.
                if (err_i) begin
                    cyc_d   = 1'b0;
                    cti_d   = 3'b000;
                    fault_d = 1'b1;
                    v_d     = 1'b1;
                    state_d = HOLD;
                end else if (ack_i) begin
                    buf_we = 1'b1;
                    if (beat_q == LAST) begin
                        cyc_d   = 1'b0;
                        cti_d   = 3'b000;
                        v_d     = 1'b1;
                        state_d = HOLD;
                    end else begin
                        beat_d = beat_q + BW'(1);
                        adr_d  = adr_q + AWID'(16);
                        cti_d  = ((beat_q + BW'(1)) == LAST) ? CTI_EOB : CTI_INCR;
                    end
                end
            end
            HOLD: begin
                req_rdy = out_rdy_i;
                if (out_rdy_i) begin
                    v_d     = 1'b0;
                    fault_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush_i) req_rdy = 1'b0;

        // New request: overrides the IDLE/HOLD-accept outcome above.
        if (req_i && req_rdy) begin
            ip_d    = req_ip_i;
            cs_d    = req_cs_i;
            pip_d   = req_pip_i;
            pt_d    = req_pt_i;
            adr_d   = {req_ip_i[AWID:7], 6'b0};
            beat_d  = '0;
            fault_d = 1'b0;
            v_d     = 1'b0;
            cyc_d   = 1'b1;
            cti_d   = CTI_FIRST;
            buf_clr = 1'b1;
            state_d = FILL;
        end

        if (flush_i) begin
            state_d = IDLE;
            beat_d  = '0;
            cyc_d   = 1'b0;
            cti_d   = 3'b000;
            v_d     = 1'b0;
            fault_d = 1'b0;
            buf_clr = 1'b1;
            buf_we  = 1'b0;
        end
    end

    assign ilf_out = '{
        v:             v_q,
        ir:            line,
        ip:            ip_q,
        cs:            cs_q,
        pip:           pip_q,
        predict_taken: pt_q,
        fault:         fault_q
    };

    assign req_rdy_o   = req_rdy;
    assign cyc_o       = cyc_q;
    assign stb_o       = cyc_q;
    assign cti_o       = cti_q;
    assign adr_o       = adr_q;
    assign out_v_o     = ilf_out.v;
    assign out_line_o  = ilf_out.ir;
    assign out_ip_o    = ilf_out.ip;
    assign out_cs_o    = ilf_out.cs;
    assign out_pip_o   = ilf_out.pip;
    assign out_pt_o    = ilf_out.predict_taken;
    assign out_fault_o = ilf_out.fault;
    assign state_o     = state_q;

endmodule
